// File: rtl/sdram_arbiter_if.sv
// Bundle of the three requester ports and the Avalon-style SDRAM master port.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface sdram_arbiter_if #(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
);
  logic              i_req0_read;
  logic              i_req0_write;
  logic [ADDR_W-1:0] i_req0_addr;
  logic [DATA_W-1:0] i_req0_writedata;
  logic [DATA_W-1:0] o_req0_readdata;
  logic              o_req0_finished;

  logic              i_req1_read;
  logic              i_req1_write;
  logic [ADDR_W-1:0] i_req1_addr;
  logic [DATA_W-1:0] i_req1_writedata;
  logic [DATA_W-1:0] o_req1_readdata;
  logic              o_req1_finished;

  logic              i_req2_read;
  logic              i_req2_write;
  logic [ADDR_W-1:0] i_req2_addr;
  logic [DATA_W-1:0] i_req2_writedata;
  logic [DATA_W-1:0] o_req2_readdata;
  logic              o_req2_finished;

  logic              o_sdram_read;
  logic              o_sdram_write;
  logic [ADDR_W-1:0] o_sdram_addr;
  logic [DATA_W-1:0] o_sdram_writedata;
  logic [DATA_W-1:0] i_sdram_readdata;
  logic              i_sdram_waitrequest;
  logic              i_sdram_readdatavalid;

  modport slave (
    input  i_req0_read, i_req0_write, i_req0_addr, i_req0_writedata,
    output o_req0_readdata, o_req0_finished,
    input  i_req1_read, i_req1_write, i_req1_addr, i_req1_writedata,
    output o_req1_readdata, o_req1_finished,
    input  i_req2_read, i_req2_write, i_req2_addr, i_req2_writedata,
    output o_req2_readdata, o_req2_finished,
    output o_sdram_read, o_sdram_write, o_sdram_addr, o_sdram_writedata,
    input  i_sdram_readdata, i_sdram_waitrequest, i_sdram_readdatavalid
  );

  modport master (
    output i_req0_read, i_req0_write, i_req0_addr, i_req0_writedata,
    input  o_req0_readdata, o_req0_finished,
    output i_req1_read, i_req1_write, i_req1_addr, i_req1_writedata,
    input  o_req1_readdata, o_req1_finished,
    output i_req2_read, i_req2_write, i_req2_addr, i_req2_writedata,
    input  o_req2_readdata, o_req2_finished,
    input  o_sdram_read, o_sdram_write, o_sdram_addr, o_sdram_writedata,
    output i_sdram_readdata, i_sdram_waitrequest, i_sdram_readdatavalid
  );
endinterface

// File: rtl/sdram_arbiter.sv
// Three-port single-word SDRAM arbiter: port 0 fixed priority, ports 1/2 round-robin,
// one outstanding command, read timeout with a sticky flag.
module sdram_arbiter #(
  parameter int ADDR_W     = 23,
  parameter int DATA_W     = 32,
  parameter int RD_TIMEOUT = 255
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  sdram_arbiter_if.slave       bus,
  output logic [2:0]           o_grant,
  output logic                 o_timeout
);

  localparam int CNT_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(RD_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RD,
    ST_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                ptr_q, ptr_d;          // 0 prefers port 1, 1 prefers port 2
  logic [2:0]          grant_q, grant_d;
  logic                op_wr_q, op_wr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                timeout_q, timeout_d;
  logic                capture;

  logic [2:0]          req_rd, req_wr, req_any;
  logic [ADDR_W-1:0]   req_addr  [3];
  logic [DATA_W-1:0]   req_wdata [3];
  logic [DATA_W-1:0]   rdata_out [3];

  logic [2:0]          win_oh;
  logic                win_wr;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_wdata;

  assign req_rd = {bus.i_req2_read,  bus.i_req1_read,  bus.i_req0_read};
  assign req_wr = {bus.i_req2_write, bus.i_req1_write, bus.i_req0_write};
  assign req_any = req_rd | req_wr;

  assign req_addr[0]  = bus.i_req0_addr;
  assign req_addr[1]  = bus.i_req1_addr;
  assign req_addr[2]  = bus.i_req2_addr;
  assign req_wdata[0] = bus.i_req0_writedata;
  assign req_wdata[1] = bus.i_req1_writedata;
  assign req_wdata[2] = bus.i_req2_writedata;

  // Winner selection; a write wins over a read on the same port.
  always_comb begin
    win_oh = 3'b000;
    if (req_any[0]) begin
      win_oh = 3'b001;
    end else if (req_any[1] && req_any[2]) begin
      win_oh = ptr_q ? 3'b100 : 3'b010;
    end else if (req_any[1]) begin
      win_oh = 3'b010;
    end else if (req_any[2]) begin
      win_oh = 3'b100;
    end

    win_wr    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < 3; i++) begin
      if (win_oh[i]) begin
        win_wr    = req_wr[i];
        win_addr  = req_addr[i];
        win_wdata = req_wdata[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    op_wr_d   = op_wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    capture   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (win_oh != 3'b000) begin
          grant_d = win_oh;
          op_wr_d = win_wr;
          addr_d  = win_addr;
          wdata_d = win_wdata;
          state_d = ST_ISSUE;
          if (win_oh[1]) begin
            ptr_d = 1'b1;
          end else if (win_oh[2]) begin
            ptr_d = 1'b0;
          end
        end
      end
      ST_ISSUE: begin
        if (!bus.i_sdram_waitrequest) begin
          if (op_wr_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT_RD;
            cnt_d   = '0;
          end
        end
      end
      ST_WAIT_RD: begin
        // Valid data wins over a timeout landing on the same cycle.
        if (bus.i_sdram_readdatavalid) begin
          capture = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_q == CNT_LIMIT) begin
          timeout_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        grant_d = 3'b000;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = 3'b000;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= ST_IDLE;
      ptr_q     <= 1'b0;
      grant_q   <= 3'b000;
      op_wr_q   <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      op_wr_q   <= op_wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Per-port read data holding registers.
  for (genvar gi = 0; gi < 3; gi++) begin : g_rdata
    logic [DATA_W-1:0] rdata_q, rdata_d;

    always_comb begin
      rdata_d = rdata_q;
      if (capture && grant_q[gi]) begin
        rdata_d = bus.i_sdram_readdata;
      end
    end

    always_ff @(posedge i_clk) begin
      if (!i_rst) begin
        rdata_q <= '0;
      end else begin
        rdata_q <= rdata_d;
      end
    end

    assign rdata_out[gi] = rdata_q;
  end

  logic issue;
  logic done;
  assign issue = (state_q == ST_ISSUE);
  assign done  = (state_q == ST_DONE);

  assign bus.o_sdram_read      = issue && !op_wr_q;
  assign bus.o_sdram_write     = issue && op_wr_q;
  assign bus.o_sdram_addr      = issue ? addr_q : '0;
  assign bus.o_sdram_writedata = (issue && op_wr_q) ? wdata_q : '0;

  assign bus.o_req0_finished = done && grant_q[0];
  assign bus.o_req1_finished = done && grant_q[1];
  assign bus.o_req2_finished = done && grant_q[2];
  assign bus.o_req0_readdata = rdata_out[0];
  assign bus.o_req1_readdata = rdata_out[1];
  assign bus.o_req2_readdata = rdata_out[2];

  assign o_grant   = grant_q;
  assign o_timeout = timeout_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: reset, stalls, arbitration order, fairness,
// read timeout and reset during a read.
module tb_sdram_arbiter;
  localparam int ADDR_W     = 23;
  localparam int DATA_W     = 32;
  localparam int RD_TIMEOUT = 255;

  logic       clk;
  logic       rst;
  logic [2:0] grant;
  logic       timeout;
  logic [2:0] fin;
  int         total;
  int         bad;

  sdram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sdram_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .RD_TIMEOUT(RD_TIMEOUT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus),
    .o_grant(grant),
    .o_timeout(timeout)
  );

  assign fin = {bus.o_req2_finished, bus.o_req1_finished, bus.o_req0_finished};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int port);
    int n;
    n = 0;
    port = -1;
    cyc();
    n++;
    while (n < 40 && fin == 3'b000) begin
      cyc();
      n++;
    end
    check("done_seen", {63'd0, fin != 3'b000}, 64'd1);
    check("grant_at_done", {61'd0, grant}, {61'd0, fin});
    if (fin[0]) port = 0;
    else if (fin[1]) port = 1;
    else if (fin[2]) port = 2;
  endtask

  initial begin
    int p;
    int n;
    int c1;
    int c2;
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.i_req0_read = 1'b0; bus.i_req0_write = 1'b0; bus.i_req0_addr = '0; bus.i_req0_writedata = '0;
    bus.i_req1_read = 1'b0; bus.i_req1_write = 1'b0; bus.i_req1_addr = '0; bus.i_req1_writedata = '0;
    bus.i_req2_read = 1'b0; bus.i_req2_write = 1'b0; bus.i_req2_addr = '0; bus.i_req2_writedata = '0;
    bus.i_sdram_readdata = '0;
    bus.i_sdram_waitrequest = 1'b0;
    bus.i_sdram_readdatavalid = 1'b0;

    // Reset then a single port 0 write.
    cyc();
    cyc();
    check("rst_grant", {61'd0, grant}, 64'd0);
    check("rst_rd_wr", {62'd0, bus.o_sdram_read, bus.o_sdram_write}, 64'd0);
    check("rst_fin", {61'd0, fin}, 64'd0);
    check("rst_timeout", {63'd0, timeout}, 64'd0);
    check("rst_rdata0", {32'd0, bus.o_req0_readdata}, 64'd0);
    rst = 1'b1;
    cyc();
    bus.i_req0_write = 1'b1;
    bus.i_req0_addr = 23'h000010;
    bus.i_req0_writedata = 32'hDEADBEEF;
    cyc();
    check("wr_strobe", {62'd0, bus.o_sdram_read, bus.o_sdram_write}, 64'd1);
    check("wr_addr", {41'd0, bus.o_sdram_addr}, 64'h10);
    check("wr_data", {32'd0, bus.o_sdram_writedata}, 64'hDEADBEEF);
    check("wr_grant", {61'd0, grant}, 64'b001);
    check("wr_fin_early", {61'd0, fin}, 64'd0);
    cyc();
    check("wr_fin", {61'd0, fin}, 64'b001);
    check("wr_strobe_drop", {63'd0, bus.o_sdram_write}, 64'd0);
    check("wr_grant_done", {61'd0, grant}, 64'b001);
    bus.i_req0_write = 1'b0;
    cyc();
    check("wr_fin_once", {61'd0, fin}, 64'd0);
    check("wr_grant_idle", {61'd0, grant}, 64'd0);

    // Port 2 read stalled by waitrequest for 4 cycles, data 3 cycles after acceptance.
    bus.i_req2_read = 1'b1;
    bus.i_req2_addr = 23'h7FFFFF;
    bus.i_sdram_waitrequest = 1'b1;
    cyc();
    bus.i_req2_addr = 23'h000001;
    for (int k = 1; k <= 5; k++) begin
      check("stall_rd", {62'd0, bus.o_sdram_read, bus.o_sdram_write}, 64'b10);
      check("stall_addr", {41'd0, bus.o_sdram_addr}, 64'h7FFFFF);
      if (k == 5) bus.i_sdram_waitrequest = 1'b0;
      cyc();
    end
    check("rd_strobe_drop", {63'd0, bus.o_sdram_read}, 64'd0);
    check("rd_grant_wait", {61'd0, grant}, 64'b100);
    cyc();
    cyc();
    bus.i_sdram_readdatavalid = 1'b1;
    bus.i_sdram_readdata = 32'h12345678;
    cyc();
    bus.i_sdram_readdatavalid = 1'b0;
    bus.i_sdram_readdata = 32'h0;
    check("rd_fin", {61'd0, fin}, 64'b100);
    check("rd_data", {32'd0, bus.o_req2_readdata}, 64'h12345678);
    bus.i_req2_read = 1'b0;
    cyc();
    check("rd_data_hold", {32'd0, bus.o_req2_readdata}, 64'h12345678);
    check("rd_fin_once", {61'd0, fin}, 64'd0);

    // All three write continuously: port 0 dominates, then 1/2 alternate.
    bus.i_req0_write = 1'b1;
    bus.i_req1_write = 1'b1;
    bus.i_req2_write = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_done(p);
      check("prio_port0", p, 0);
    end
    bus.i_req0_write = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wait_done(p);
      check("rr_write_order", p, (k % 2 == 0) ? 1 : 2);
    end
    bus.i_req1_write = 1'b0;
    bus.i_req2_write = 1'b0;
    cyc();

    // Fairness after reset: reads from ports 1 and 2, pointer starts at port 1.
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    bus.i_req1_read = 1'b1;
    bus.i_req2_read = 1'b1;
    bus.i_sdram_readdatavalid = 1'b1;
    c1 = 0;
    c2 = 0;
    for (int k = 0; k < 6; k++) begin
      bus.i_sdram_readdata = 32'hA0000000 + k;
      wait_done(p);
      check("rr_read_order", p, (k % 2 == 0) ? 1 : 2);
      check("rr_read_data", {32'd0, (p == 1) ? bus.o_req1_readdata : bus.o_req2_readdata},
            {32'd0, 32'hA0000000 + k});
      if (p == 1) c1++;
      if (p == 2) c2++;
    end
    check("rr_count1", c1, 3);
    check("rr_count2", c2, 3);
    bus.i_req1_read = 1'b0;
    bus.i_req2_read = 1'b0;
    bus.i_sdram_readdatavalid = 1'b0;
    cyc();

    // Port 1 read that never gets data.
    bus.i_req1_read = 1'b1;
    cyc();
    check("to_issue", {62'd0, bus.o_sdram_read, bus.o_sdram_write}, 64'b10);
    check("to_grant", {61'd0, grant}, 64'b010);
    check("to_flag_before", {63'd0, timeout}, 64'd0);
    cyc();
    n = 0;
    while (fin == 3'b000 && n < 400) begin
      cyc();
      n++;
    end
    check("to_cycles", n, RD_TIMEOUT + 1);
    check("to_fin", {61'd0, fin}, 64'b010);
    check("to_flag", {63'd0, timeout}, 64'd1);
    check("to_rdata_kept", {32'd0, bus.o_req1_readdata}, 64'hA0000004);
    bus.i_req1_read = 1'b0;
    cyc();
    cyc();
    check("to_flag_sticky", {63'd0, timeout}, 64'd1);
    check("to_fin_once", {61'd0, fin}, 64'd0);

    // Reset while a port 2 read waits for data.
    bus.i_req2_read = 1'b1;
    cyc();
    cyc();
    cyc();
    check("mid_grant_before", {61'd0, grant}, 64'b100);
    rst = 1'b0;
    cyc();
    check("mid_grant", {61'd0, grant}, 64'd0);
    check("mid_fin", {61'd0, fin}, 64'd0);
    check("mid_timeout", {63'd0, timeout}, 64'd0);
    check("mid_rdata1", {32'd0, bus.o_req1_readdata}, 64'd0);
    rst = 1'b1;
    bus.i_req2_read = 1'b0;
    bus.i_sdram_readdatavalid = 1'b1;
    bus.i_sdram_readdata = 32'h00000BAD;
    cyc();
    check("late_fin", {61'd0, fin}, 64'd0);
    cyc();
    bus.i_sdram_readdatavalid = 1'b0;
    check("late_rdata2", {32'd0, bus.o_req2_readdata}, 64'd0);
    check("late_fin2", {61'd0, fin}, 64'd0);
    check("late_strobe", {62'd0, bus.o_sdram_read, bus.o_sdram_write}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM master port between three requesters:
  - port 0 = load core (initial audio preload),
  - port 1 = record path (writes),
  - port 2 = playback path (reads).
- Accepts one single-word transaction at a time, drives the Avalon-style SDRAM controller interface, and returns a one-cycle finished pulse (plus read data) to the granted requester.
- Sits between the top-level controller's datapath cores and the SDRAM controller IP.

Parameters:
- ADDR_W, 23, SDRAM word address width
- DATA_W, 32, data word width
- RD_TIMEOUT, 255, max cycles waiting for readdatavalid before a read is force-completed

Ports:
- i_clk  in  1  system clock; all logic on rising edge
- i_rst  in  1  synchronous reset, active-low (0 = reset)
- i_reqN_read  in  1  port N read request, N=0..2; held until o_reqN_finished
- i_reqN_write  in  1  port N write request, N=0..2; held until o_reqN_finished
- i_reqN_addr  in  ADDR_W  port N address
- i_reqN_writedata  in  DATA_W  port N write data
- o_reqN_readdata  out  DATA_W  port N read data; valid when o_reqN_finished=1 after a read, held until the next read completes on that port
- o_reqN_finished  out  1  one-cycle completion pulse to port N
- o_sdram_read  out  1  SDRAM read strobe
- o_sdram_write  out  1  SDRAM write strobe
- o_sdram_addr  out  ADDR_W  SDRAM address
- o_sdram_writedata  out  DATA_W  SDRAM write data
- i_sdram_readdata  in  DATA_W  SDRAM read data
- i_sdram_waitrequest  in  1  SDRAM stall; command held while 1
- i_sdram_readdatavalid  in  1  read data valid
- o_grant  out  3  one-hot current owner; 0 when idle
- o_timeout  out  1  sticky flag: a read timed out; cleared only by reset

Behaviour:
- Reset (i_rst=0 at a clock edge):
  - All outputs go to 0 and readdata registers clear.
  - State goes to IDLE and the round-robin pointer goes to port 1.
  - Reset mid-transaction abandons it immediately with no finished pulse.
- States: IDLE -> ISSUE -> (WAIT_RD) -> DONE -> IDLE.
- IDLE:
  - A port is requesting if its read or write input is high.
  - Port 0 has fixed highest priority.
  - Between ports 1 and 2, the winner is the port the pointer selects, else the other port.
  - On a winner: latch addr, writedata and op; set o_grant; go to ISSUE.
  - Write has precedence if both read and write are high on the winning port.
  - The pointer flips to the non-winner whenever port 1 or 2 is granted; a port 0 grant leaves it unchanged.
- ISSUE:
  - Drive o_sdram_read or o_sdram_write (exactly one) with the latched addr/data.
  - Hold all of them stable while i_sdram_waitrequest=1.
  - On the first cycle with waitrequest=0, the command is accepted and the strobe drops next cycle.
  - An accepted write goes to DONE; an accepted read goes to WAIT_RD and clears the timeout counter.
- WAIT_RD:
  - On i_sdram_readdatavalid=1, capture i_sdram_readdata into the granted port's readdata register and go to DONE.
  - The counter increments each cycle without valid.
  - When the counter reaches RD_TIMEOUT: set o_timeout, leave readdata unchanged, go to DONE.
- DONE:
  - o_reqN_finished=1 for the granted port for exactly one cycle; o_grant is still asserted.
  - Next state is IDLE, which clears o_grant.
  - The requester must deassert its request or present the next op by the following (IDLE) cycle.
- Latched commands:
  - Requests are latched at grant; dropping or changing request inputs after grant does not affect the in-flight transaction.
  - Requests arriving during a busy state wait; none are lost while held.
- Latency:
  - Write with no waitrequest: request seen in IDLE at cycle t, strobe at t+1, finished at t+2.
  - Read: finished one cycle after readdatavalid.
- At most one SDRAM command is outstanding at any time. o_sdram_read and o_sdram_write are never both 1.

Test Plan:
- Reset then idle: hold i_rst=0 for 2 cycles -> all outputs 0, o_grant=000; raising only i_req0_write with addr 0x000010, data 0xDEADBEEF -> o_sdram_write=1 with those values one cycle later, o_req0_finished pulse 2 cycles after the request.
- Waitrequest stall: port 2 read at 0x7FFFFF, waitrequest high for 4 cycles, readdatavalid 3 cycles after acceptance with 0x12345678 -> strobe held stable for 5 cycles, o_req2_readdata=0x12345678 on the finished pulse.
- Arbitration: ports 0, 1 and 2 all request writes simultaneously and continuously -> grant order 0,0,0,... while port 0 holds; once port 0 drops, order is 1,2,1,2.
- Round-robin fairness: ports 1 and 2 both hold read requests for 6 transactions -> exactly 3 grants each, alternating, starting with port 1 after reset.
- Timeout: a port 1 read is accepted and readdatavalid never arrives -> o_req1_finished after RD_TIMEOUT+1 cycles in WAIT_RD, o_timeout=1 and stays 1, previous readdata unchanged.
- Reset mid-read: assert i_rst=0 while in WAIT_RD -> next cycle outputs are 0 and no finished pulse occurs; a late readdatavalid after reset is ignored.
